// File: rtl/hdlc_rx_channel_if.sv
// Line side and Rx_* result signals of the HDLC receive channel.
// The line driver is the master; the receive channel is the slave.
interface hdlc_rx_channel_if;
  logic       Rx;
  logic       RxEN;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_ValidFrame;
  logic       Rx_StartZeroDetect;
  logic       Rx_StartFCS;
  logic       Rx_StopFCS;
  logic       Rx_EoF;
  logic       Rx_FrameError;
  logic       Rx_AbortSignal;

  modport master (
    output Rx, RxEN,
    input  Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame,
           Rx_StartZeroDetect, Rx_StartFCS, Rx_StopFCS, Rx_EoF, Rx_FrameError,
           Rx_AbortSignal
  );

  modport slave (
    input  Rx, RxEN,
    output Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame,
           Rx_StartZeroDetect, Rx_StartFCS, Rx_StopFCS, Rx_EoF, Rx_FrameError,
           Rx_AbortSignal
  );
endinterface

// File: rtl/hdlc_rx_channel.sv
// HDLC bit-level receiver: flag hunt, zero destuffing, abort detection and LSB-first
// byte assembly with frame delimiter / error pulses.
module hdlc_rx_channel #(
  parameter int unsigned IDLE_ONES = 7
) (
  input logic               Clk,
  input logic               Rst,
  hdlc_rx_channel_if.slave  bus
);

  // Abort pattern: a 0 followed by IDLE_ONES ones, oldest bit at [0].
  localparam logic [7:0] AbortMask = 8'(8'hFF << (7 - IDLE_ONES));
  localparam logic [7:0] AbortPat  = 8'(8'hFF << (8 - IDLE_ONES));

  typedef enum logic [1:0] {StIdle, StFlagSeen, StInFrame} state_e;

  logic       rxd_q, rxd_d;
  logic       rxd_vld_q, rxd_vld_d;
  logic [7:0] raw_q, raw_d;
  logic [7:0] raw_vld_q, raw_vld_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_cmp_q, byte_cmp_d;
  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       new_byte_q, new_byte_d;
  logic       valid_q, valid_d;
  logic       start_fcs_q, start_fcs_d;
  logic       stop_fcs_q, stop_fcs_d;
  logic       eof_q, eof_d;
  logic       frame_err_q, frame_err_d;
  logic       abort_sig_q, abort_sig_d;

  logic flag_det, abort_det, stuffed;

  // Detection waits for eight genuine line bits so the cleared register cannot mimic an abort.
  assign flag_det  = (&raw_vld_q) && (raw_q == 8'h7E);
  assign abort_det = (&raw_vld_q) && ((raw_q & AbortMask) == AbortPat);
  assign stuffed   = (state_q != StIdle) && !rxd_q && (ones_q == 3'd5);

  always_comb begin
    rxd_d      = bus.Rx;
    rxd_vld_d  = 1'b1;
    raw_d      = {rxd_q, raw_q[7:1]};
    raw_vld_d  = {rxd_vld_q, raw_vld_q[7:1]};
    ones_d     = rxd_q ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cmp_d = 1'b0;
    if (!stuffed) begin
      shift_d    = {rxd_q, shift_q[7:1]};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      byte_cmp_d = (bit_cnt_q == 3'd7);
    end
    // The bit shifted alongside a flag detect is the first bit of the next byte.
    if (flag_det) begin
      bit_cnt_d  = stuffed ? 3'd0 : 3'd1;
      byte_cmp_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    valid_d     = valid_q;
    new_byte_d  = 1'b0;
    start_fcs_d = 1'b0;
    stop_fcs_d  = 1'b0;
    eof_d       = 1'b0;
    frame_err_d = 1'b0;
    abort_sig_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flag_det) state_d = StFlagSeen;
      end
      StFlagSeen: begin
        if (abort_det) begin
          state_d = StIdle;
        end else if (!flag_det && byte_cmp_q) begin
          state_d     = StInFrame;
          valid_d     = 1'b1;
          new_byte_d  = 1'b1;
          start_fcs_d = 1'b1;
          data_d      = shift_q;
        end
      end
      StInFrame: begin
        if (abort_det) begin
          state_d     = StIdle;
          abort_sig_d = 1'b1;
          eof_d       = 1'b1;
          valid_d     = 1'b0;
        end else if (flag_det) begin
          state_d     = StFlagSeen;
          eof_d       = 1'b1;
          stop_fcs_d  = byte_cmp_q;
          frame_err_d = !byte_cmp_q;
          valid_d     = 1'b0;
        end else if (byte_cmp_q) begin
          new_byte_d = 1'b1;
          data_d     = shift_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst || !bus.RxEN) begin
      rxd_q       <= 1'b0;
      rxd_vld_q   <= 1'b0;
      raw_q       <= 8'h00;
      raw_vld_q   <= 8'h00;
      shift_q     <= 8'h00;
      ones_q      <= 3'd0;
      bit_cnt_q   <= 3'd0;
      byte_cmp_q  <= 1'b0;
      state_q     <= StIdle;
      data_q      <= 8'h00;
      new_byte_q  <= 1'b0;
      valid_q     <= 1'b0;
      start_fcs_q <= 1'b0;
      stop_fcs_q  <= 1'b0;
      eof_q       <= 1'b0;
      frame_err_q <= 1'b0;
      abort_sig_q <= 1'b0;
    end else begin
      rxd_q       <= rxd_d;
      rxd_vld_q   <= rxd_vld_d;
      raw_q       <= raw_d;
      raw_vld_q   <= raw_vld_d;
      shift_q     <= shift_d;
      ones_q      <= ones_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cmp_q  <= byte_cmp_d;
      state_q     <= state_d;
      data_q      <= data_d;
      new_byte_q  <= new_byte_d;
      valid_q     <= valid_d;
      start_fcs_q <= start_fcs_d;
      stop_fcs_q  <= stop_fcs_d;
      eof_q       <= eof_d;
      frame_err_q <= frame_err_d;
      abort_sig_q <= abort_sig_d;
    end
  end

  assign bus.Rx_Data            = data_q;
  assign bus.Rx_NewByte         = new_byte_q;
  assign bus.Rx_FlagDetect      = flag_det;
  assign bus.Rx_AbortDetect     = abort_det;
  assign bus.Rx_ValidFrame      = valid_q;
  assign bus.Rx_StartZeroDetect = (state_q != StIdle);
  assign bus.Rx_StartFCS        = start_fcs_q;
  assign bus.Rx_StopFCS         = stop_fcs_q;
  assign bus.Rx_EoF             = eof_q;
  assign bus.Rx_FrameError      = frame_err_q;
  assign bus.Rx_AbortSignal     = abort_sig_q;

endmodule

// File: tb/tb_hdlc_rx_channel.sv
// Directed bench for hdlc_rx_channel: idle line, normal frames, destuffing, abort,
// misaligned close and mid-frame reset / disable.
module tb_hdlc_rx_channel;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hdlc_rx_channel_if bus ();

  hdlc_rx_channel #(.IDLE_ONES(7)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Monitor tallies, sampled on the falling edge.
  int nb_cnt = 0, sf_cnt = 0, st_cnt = 0, eof_cnt = 0, fe_cnt = 0, ab_cnt = 0;
  int fd_cnt = 0, ad_cnt = 0, vf_cnt = 0, viol = 0;
  logic [7:0] byte_log [64];
  logic [5:0] prev_pulses = '0;
  logic [5:0] pulses;

  int b_nb, b_sf, b_st, b_eof, b_fe, b_ab, b_fd, b_ad, b_vf;

  always @(negedge clk) begin
    if (bus.Rx_NewByte) begin
      byte_log[nb_cnt % 64] = bus.Rx_Data;
      nb_cnt++;
    end
    if (bus.Rx_StartFCS)    sf_cnt++;
    if (bus.Rx_StopFCS)     st_cnt++;
    if (bus.Rx_EoF)         eof_cnt++;
    if (bus.Rx_FrameError)  fe_cnt++;
    if (bus.Rx_AbortSignal) ab_cnt++;
    if (bus.Rx_FlagDetect)  fd_cnt++;
    if (bus.Rx_AbortDetect) ad_cnt++;
    if (bus.Rx_ValidFrame)  vf_cnt++;
    if (bus.Rx_NewByte && bus.Rx_EoF) viol++;
    if (bus.Rx_StartFCS && !bus.Rx_NewByte) viol++;
    if ((bus.Rx_StopFCS || bus.Rx_FrameError || bus.Rx_AbortSignal) && !bus.Rx_EoF) viol++;
    pulses = {bus.Rx_NewByte, bus.Rx_StartFCS, bus.Rx_StopFCS, bus.Rx_EoF,
              bus.Rx_FrameError, bus.Rx_AbortSignal};
    if (|(pulses & prev_pulses)) viol++;
    prev_pulses = pulses;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_nb = nb_cnt; b_sf = sf_cnt; b_st = st_cnt; b_eof = eof_cnt; b_fe = fe_cnt;
    b_ab = ab_cnt; b_fd = fd_cnt; b_ad = ad_cnt; b_vf = vf_cnt;
  endtask

  task automatic send_bit(input logic b);
    bus.Rx = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  function automatic logic [17:0] outs();
    return {bus.Rx_Data, bus.Rx_NewByte, bus.Rx_FlagDetect, bus.Rx_AbortDetect,
            bus.Rx_ValidFrame, bus.Rx_StartZeroDetect, bus.Rx_StartFCS, bus.Rx_StopFCS,
            bus.Rx_EoF, bus.Rx_FrameError, bus.Rx_AbortSignal};
  endfunction

  initial begin
    bus.Rx   = 1'b1;
    bus.RxEN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outs", 32'(outs()), 32'h0);

    // Idle line of ones: nothing detected.
    snap();
    idle(40);
    check("idle_fd", fd_cnt - b_fd, 0);
    check("idle_ad", ad_cnt - b_ad, 0);
    check("idle_nb", nb_cnt - b_nb, 0);
    check("idle_vf", vf_cnt - b_vf, 0);

    // Flag, A5, 3C, flag.
    snap();
    send_byte(8'h7E);
    @(negedge clk);
    check("flag_lat_early", bus.Rx_FlagDetect, 1'b0);
    send_bit(1'b1);
    @(negedge clk);
    check("flag_lat_2clk", bus.Rx_FlagDetect, 1'b1);
    check("flag_szd", bus.Rx_StartZeroDetect, 1'b0);
    send_bits(16'h0052, 7);
    send_byte(8'h3C);
    send_byte(8'h7E);
    idle(12);
    check("f1_nb", nb_cnt - b_nb, 2);
    check("f1_byte0", byte_log[b_nb % 64], 8'hA5);
    check("f1_byte1", byte_log[(b_nb + 1) % 64], 8'h3C);
    check("f1_sfcs", sf_cnt - b_sf, 1);
    check("f1_eof", eof_cnt - b_eof, 1);
    check("f1_stop", st_cnt - b_st, 1);
    check("f1_ferr", fe_cnt - b_fe, 0);
    check("f1_abort", ab_cnt - b_ab, 0);

    // Flag, FF with stuffed zero, flag.
    snap();
    send_byte(8'h7E);
    send_bits(16'h01DF, 9);
    send_byte(8'h7E);
    idle(12);
    check("ff_nb", nb_cnt - b_nb, 1);
    check("ff_byte", byte_log[b_nb % 64], 8'hFF);
    check("ff_stop", st_cnt - b_st, 1);
    check("ff_ferr", fe_cnt - b_fe, 0);

    // Flag, 12, then 0 and seven ones.
    snap();
    send_byte(8'h7E);
    send_byte(8'h12);
    send_bit(1'b0);
    idle(7);
    send_bit(1'b1);
    @(negedge clk);
    check("ab_detect", bus.Rx_AbortDetect, 1'b1);
    check("ab_sig_early", bus.Rx_AbortSignal, 1'b0);
    check("ab_vf_before", bus.Rx_ValidFrame, 1'b1);
    send_bit(1'b1);
    @(negedge clk);
    check("ab_sig", bus.Rx_AbortSignal, 1'b1);
    check("ab_eof", bus.Rx_EoF, 1'b1);
    check("ab_vf_after", bus.Rx_ValidFrame, 1'b0);
    check("ab_szd", bus.Rx_StartZeroDetect, 1'b0);
    send_bit(1'b1);
    @(negedge clk);
    check("ab_sig_width", bus.Rx_AbortSignal, 1'b0);
    idle(8);
    check("ab_nb", nb_cnt - b_nb, 1);
    check("ab_byte", byte_log[b_nb % 64], 8'h12);
    check("ab_stop", st_cnt - b_st, 0);
    check("ab_ferr", fe_cnt - b_fe, 0);

    // Flag, 55, three extra bits, flag: misaligned close.
    snap();
    send_byte(8'h7E);
    send_byte(8'h55);
    send_bits(16'h0005, 3);
    send_byte(8'h7E);
    idle(12);
    check("fe_nb", nb_cnt - b_nb, 2);
    check("fe_byte0", byte_log[b_nb % 64], 8'h55);
    check("fe_byte1", byte_log[(b_nb + 1) % 64], 8'hF5);
    check("fe_eof", eof_cnt - b_eof, 1);
    check("fe_ferr", fe_cnt - b_fe, 1);
    check("fe_stop", st_cnt - b_st, 0);

    // Mid-byte reset inside an open frame.
    snap();
    send_byte(8'h7E);
    send_byte(8'hAA);
    send_bits(16'h000D, 4);
    @(negedge clk);
    check("rst_pre_vf", bus.Rx_ValidFrame, 1'b1);
    check("rst_pre_byte", byte_log[b_nb % 64], 8'hAA);
    rst = 1'b1;
    send_bit(1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_outs", 32'(outs()), 32'h0);
    snap();
    send_byte(8'h4D);
    idle(4);
    check("rst_nb", nb_cnt - b_nb, 0);
    check("rst_vf", vf_cnt - b_vf, 0);
    check("rst_szd", bus.Rx_StartZeroDetect, 1'b0);

    // Same with the enable dropped for one cycle.
    snap();
    send_byte(8'h7E);
    send_byte(8'hAA);
    send_bits(16'h000D, 4);
    @(negedge clk);
    check("en_pre_vf", bus.Rx_ValidFrame, 1'b1);
    bus.RxEN = 1'b0;
    send_bit(1'b0);
    bus.RxEN = 1'b1;
    @(negedge clk);
    check("en_outs", 32'(outs()), 32'h0);
    snap();
    send_byte(8'h4D);
    idle(4);
    check("en_nb", nb_cnt - b_nb, 0);
    check("en_vf", vf_cnt - b_vf, 0);
    check("en_szd", bus.Rx_StartZeroDetect, 1'b0);

    check("protocol_viol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
